// File: rtl/laser_echo_pkg.sv
// Shared types and defaults for the laser echo responder block.
// The optional dropped-echo feature is enabled by defining LASER_ECHO_DROP_EN.
package laser_echo_pkg;

  localparam int LASER_ECHO_WIDTH  = 16;
  localparam int LASER_ECHO_DROP_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    ECHO = 2'd2
  } state_t;

endpackage

// File: rtl/laser_echo_responder_if.sv
// Meter-side signal bundle for the laser echo responder: shot/program inputs
// from the distance meter and echo/status outputs back to it.
interface laser_echo_responder_if
  import laser_echo_pkg::*;
#(
  parameter int WIDTH = LASER_ECHO_WIDTH
) ();

  logic             L;
  logic [WIDTH-1:0] Dset;
  logic             Dld;
  logic             S;
  logic             busy;
  logic             ovr;
  logic [7:0]       echoes;

  modport master (
    output L, Dset, Dld,
    input  S, busy, ovr, echoes
  );

  modport slave (
    input  L, Dset, Dld,
    output S, busy, ovr, echoes
  );

endinterface

// File: rtl/laser_echo_timer.sv
// Loadable flight-time down-counter; holds at zero instead of wrapping so
// the full 0..2^WIDTH-1 distance range is usable.
module laser_echo_timer
  import laser_echo_pkg::*;
#(
  parameter int WIDTH = LASER_ECHO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_zero = w_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/laser_echo_responder.sv
// Laser echo responder: answers a shot on L with a one-cycle S pulse N+2 cycles
// later. Defining LASER_ECHO_DROP_EN suppresses the echo of every DROP_N-th shot.
module laser_echo_responder
  import laser_echo_pkg::*;
#(
  parameter int WIDTH  = LASER_ECHO_WIDTH,
  parameter int DROP_N = LASER_ECHO_DROP_N
) (
  input  logic                  clk,
  input  logic                  reset,
  laser_echo_responder_if.slave bus
);

  if (DROP_N < 2 || DROP_N > 15) begin : g_bad_drop_n
    $error("laser_echo_responder: DROP_N must be in 2..15");
  end

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_in_fly;
  logic             w_in_echo;
  logic             w_busy;
  logic             w_zero;
  logic             w_echo_pulse;
  logic [WIDTH-1:0] r_dist;
  logic [WIDTH-1:0] w_load_val;
  logic             r_ovr;
  logic [7:0]       r_echoes;

  // A same-cycle load must apply to the shot accepted in that cycle.
  assign w_load_val = bus.Dld ? bus.Dset : r_dist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_in_fly  = 1'b0;
    w_in_echo = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.L) begin
          w_accept = 1'b1;
          w_next   = FLY;
        end
      end
      FLY: begin
        w_in_fly = 1'b1;
        w_busy   = 1'b1;
        if (w_zero) begin
          w_next = ECHO;
        end
      end
      ECHO: begin
        w_in_echo = 1'b1;
        w_busy    = 1'b1;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  laser_echo_timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (w_in_fly),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dist <= '0;
    end else if (bus.Dld) begin
      r_dist <= bus.Dset;
    end
  end

`ifdef LASER_ECHO_DROP_EN
  localparam logic [3:0] LP_SHOT_LAST = 4'(DROP_N - 1);

  logic [3:0] r_shot_cnt;
  logic       r_drop;

  // The drop decision is latched at acceptance so it stays fixed for the whole flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shot_cnt <= '0;
      r_drop     <= 1'b0;
    end else if (w_accept) begin
      r_drop     <= (r_shot_cnt == LP_SHOT_LAST);
      r_shot_cnt <= (r_shot_cnt == LP_SHOT_LAST) ? 4'd0 : r_shot_cnt + 4'd1;
    end
  end

  assign w_echo_pulse = w_in_echo && !r_drop;
`else
  assign w_echo_pulse = w_in_echo;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovr <= 1'b0;
    end else if (bus.L && w_busy) begin
      r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_echoes <= 8'd0;
    end else if (w_echo_pulse) begin
      r_echoes <= r_echoes + 8'd1;
    end
  end

  assign bus.S      = w_echo_pulse;
  assign bus.busy   = w_busy;
  assign bus.ovr    = r_ovr;
  assign bus.echoes = r_echoes;

endmodule

// File: tb/tb_laser_echo_responder.sv
// Scoreboard bench for laser_echo_responder: stimulus queues the expected S cycle,
// a negedge monitor pops it whenever S is seen. Cycle 0 begins at reset release.
module tb_laser_echo_responder;
  import laser_echo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   errors = 0;
  int   checks = 0;
  int   exp_s[$];

  laser_echo_responder_if bus ();

  laser_echo_responder dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  // Monitor: every S pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.S === 1'b1) begin
      if (exp_s.size() == 0) chk("unexpected_S", cyc, -1);
      else                   chk("S_cycle", cyc, exp_s.pop_front());
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_l(input int c);
    go_to(c);
    bus.L = 1'b1;
    @(negedge clk);
    bus.L = 1'b0;
  endtask

  task automatic load(input int c, input logic [15:0] v);
    go_to(c);
    bus.Dld  = 1'b1;
    bus.Dset = v;
    @(negedge clk);
    bus.Dld  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    chk({tag, "_sb_drained"}, exp_s.size(), 0);
    exp_s.delete();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.L    = 1'b0;
    bus.Dld  = 1'b0;
    bus.Dset = '0;
    #1;
    chk({tag, "_rst_S"}, bus.S, 0);
    chk({tag, "_rst_busy"}, bus.busy, 0);
    chk({tag, "_rst_ovr"}, bus.ovr, 0);
    chk({tag, "_rst_echoes"}, bus.echoes, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.L    = 1'b0;
    bus.Dld  = 1'b0;
    bus.Dset = '0;

    // Basic shot, N=5 at cycle 10: S at 17, busy 11..17.
    do_reset("t1");
    load(2, 16'd5);
    go_to(10);
    chk("t1_busy_c10", bus.busy, 0);
    exp_s.push_back(17);
    pulse_l(10);
    chk("t1_busy_c11", bus.busy, 1);
    go_to(17);
    chk("t1_busy_c17", bus.busy, 1);
    go_to(18);
    chk("t1_busy_c18", bus.busy, 0);
    chk("t1_echoes", bus.echoes, 1);
    chk("t1_ovr", bus.ovr, 0);

    // N=0 and N=max.
    do_reset("t2");
    load(1, 16'd0);
    exp_s.push_back(6);
    pulse_l(4);
    go_to(8);
    chk("t2_echoes_n0", bus.echoes, 1);
    load(10, 16'hFFFF);
    exp_s.push_back(12 + 65537);
    pulse_l(12);
    go_to(30000);
    chk("t2_busy_mid", bus.busy, 1);
    go_to(65549);
    chk("t2_busy_last", bus.busy, 1);
    go_to(65550);
    chk("t2_busy_after", bus.busy, 0);
    chk("t2_echoes_max", bus.echoes, 2);

    // Same-cycle load+shot uses new value; load during flight does not disturb it.
    do_reset("t3");
    load(2, 16'd4);
    go_to(20);
    bus.Dld  = 1'b1;
    bus.Dset = 16'd9;
    bus.L    = 1'b1;
    exp_s.push_back(31);
    @(negedge clk);
    bus.Dld = 1'b0;
    bus.L   = 1'b0;
    load(25, 16'd2);
    go_to(31);
    chk("t3_busy_c31", bus.busy, 1);
    go_to(32);
    chk("t3_busy_c32", bus.busy, 0);
    exp_s.push_back(39);
    pulse_l(35);
    go_to(41);
    chk("t3_echoes", bus.echoes, 2);

    // Shot during flight: ignored, sets sticky ovr.
    do_reset("t4");
    load(1, 16'd6);
    exp_s.push_back(13);
    pulse_l(5);
    go_to(8);
    chk("t4_ovr_before", bus.ovr, 0);
    pulse_l(8);
    chk("t4_ovr_set", bus.ovr, 1);
    go_to(20);
    chk("t4_ovr_held", bus.ovr, 1);
    chk("t4_echoes", bus.echoes, 1);
    exp_s.push_back(28);
    pulse_l(20);
    go_to(30);
    chk("t4_ovr_sticky", bus.ovr, 1);
    chk("t4_echoes2", bus.echoes, 2);

    // Reset mid-flight: no echo, everything cleared, next shot uses dist 0.
    do_reset("t5");
    load(1, 16'd10);
    pulse_l(5);
    go_to(9);
    chk("t5_busy_fly", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_S", bus.S, 0);
    chk("t5_async_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go_to(30);
    chk("t5_busy_after", bus.busy, 0);
    chk("t5_echoes_after", bus.echoes, 0);
    chk("t5_ovr_after", bus.ovr, 0);
    exp_s.push_back(37);
    pulse_l(35);
    go_to(40);
    chk("t5_echoes_next", bus.echoes, 1);

`ifdef LASER_ECHO_DROP_EN
    // Every fourth shot has its echo suppressed but keeps the busy window.
    do_reset("t6");
    load(1, 16'd1);
    for (int k = 1; k <= 8; k++) begin
      if (k % 4 != 0) exp_s.push_back(10 * k + 3);
      pulse_l(10 * k);
      go_to(10 * k + 3);
      chk($sformatf("t6_busy_shot%0d", k), bus.busy, 1);
      go_to(10 * k + 4);
      chk($sformatf("t6_idle_shot%0d", k), bus.busy, 0);
    end
    chk("t6_echoes", bus.echoes, 6);
`endif

    repeat (3) @(negedge clk);
    chk("final_sb_drained", exp_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
